// File: rtl/ir_nec_ctrl_rx.sv
// NEC IR frame decoder: measures burst/space widths in microseconds, assembles
// 32-bit frames and maps recognised commands onto a held 3-bit motion code.
module ir_nec_ctrl_rx #(
  parameter int         CLKS_PER_US = 50,
  parameter int         HOLD_MS     = 120,
  parameter bit         CHECK_ADDR  = 1'b1,
  parameter logic [7:0] KEY_LEFT    = 8'h08,
  parameter logic [7:0] KEY_RIGHT   = 8'h5A,
  parameter logic [7:0] KEY_FWD     = 8'h18,
  parameter logic [7:0] KEY_FAST    = 8'h1C,
  parameter logic [7:0] KEY_STOP    = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic [2:0] state_control,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       repeat_pulse,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_LOW, S_LEAD_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_BURST, S_REP_BURST
  } state_t;

  state_t      state_reg, state_next;
  logic        sync1_reg, sync2_reg, prev_reg, fall_reg, rise_reg;
  logic [15:0] pre_cnt_reg, dur_us_reg;
  logic        tick;
  logic [4:0]  bit_cnt_reg;
  logic [31:0] data_reg;
  logic [15:0] hold_ms_reg;
  logic [9:0]  hold_us_reg;
  logic        hold_active_reg;

  logic        ev_err, ev_end, ev_rep, ev_bit, bit_val;
  logic        frame_ok, rep_ok, err_next, key_hit;
  logic [2:0]  key_code;
  logic [7:0]  addr_f, addr_n_f, cmd_f, cmd_n_f;

  function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Longest legal duration in each state; exceeding it aborts without an edge.
  function automatic logic [15:0] state_max(input state_t s);
    case (s)
      S_LEAD_LOW:  return 16'd10000;
      S_LEAD_HIGH: return 16'd5000;
      S_BIT_HIGH:  return 16'd1900;
      S_BIT_LOW, S_END_BURST, S_REP_BURST: return 16'd700;
      default:     return 16'hFFFF;
    endcase
  endfunction

  // ir_in idles high, so the synchroniser resets to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      fall_reg  <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync1_reg <= ir_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      fall_reg  <= prev_reg & ~sync2_reg;
      rise_reg  <= ~prev_reg & sync2_reg;
    end
  end

  assign tick = (pre_cnt_reg == 16'(CLKS_PER_US - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_reg <= '0;
      dur_us_reg  <= '0;
    end else begin
      pre_cnt_reg <= tick ? 16'd0 : pre_cnt_reg + 16'd1;
      if (fall_reg || rise_reg)
        dur_us_reg <= '0;
      else if (tick && dur_us_reg != 16'hFFFF)
        dur_us_reg <= dur_us_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ev_err     = 1'b0;
    ev_end     = 1'b0;
    ev_rep     = 1'b0;
    ev_bit     = 1'b0;
    bit_val    = 1'b0;
    if (state_reg != S_IDLE && dur_us_reg > state_max(state_reg)) begin
      ev_err     = 1'b1;
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (fall_reg) state_next = S_LEAD_LOW;
        S_LEAD_LOW: if (rise_reg) begin
          if (in_win(dur_us_reg, 16'd8000, 16'd10000)) state_next = S_LEAD_HIGH;
          else begin ev_err = 1'b1; state_next = S_IDLE; end
        end
        S_LEAD_HIGH: if (fall_reg) begin
          if (in_win(dur_us_reg, 16'd4000, 16'd5000))      state_next = S_BIT_LOW;
          else if (in_win(dur_us_reg, 16'd2000, 16'd2500)) state_next = S_REP_BURST;
          else begin ev_err = 1'b1; state_next = S_IDLE; end
        end
        S_BIT_LOW: if (rise_reg) begin
          if (in_win(dur_us_reg, 16'd400, 16'd700)) state_next = S_BIT_HIGH;
          else begin ev_err = 1'b1; state_next = S_IDLE; end
        end
        S_BIT_HIGH: if (fall_reg) begin
          if (in_win(dur_us_reg, 16'd400, 16'd700)) ev_bit = 1'b1;
          else if (in_win(dur_us_reg, 16'd1400, 16'd1900)) begin
            ev_bit  = 1'b1;
            bit_val = 1'b1;
          end else begin
            ev_err     = 1'b1;
            state_next = S_IDLE;
          end
          if (ev_bit) state_next = (bit_cnt_reg == 5'd31) ? S_END_BURST : S_BIT_LOW;
        end
        S_END_BURST: if (rise_reg) begin
          ev_end     = in_win(dur_us_reg, 16'd400, 16'd700);
          ev_err     = ~ev_end;
          state_next = S_IDLE;
        end
        S_REP_BURST: if (rise_reg) begin
          ev_rep     = in_win(dur_us_reg, 16'd400, 16'd700);
          ev_err     = ~ev_rep;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign addr_f   = data_reg[7:0];
  assign addr_n_f = data_reg[15:8];
  assign cmd_f    = data_reg[23:16];
  assign cmd_n_f  = data_reg[31:24];

  always_comb begin
    frame_ok = ev_end && ((cmd_f ^ cmd_n_f) == 8'hFF)
               && (!CHECK_ADDR || ((addr_f ^ addr_n_f) == 8'hFF));
    rep_ok   = ev_rep && hold_active_reg;
    err_next = ev_err || (ev_end && !frame_ok);
    key_hit  = 1'b1;
    key_code = 3'b000;
    if      (cmd_f == KEY_LEFT)  key_code = 3'b001;
    else if (cmd_f == KEY_RIGHT) key_code = 3'b010;
    else if (cmd_f == KEY_FWD)   key_code = 3'b011;
    else if (cmd_f == KEY_FAST)  key_code = 3'b101;
    else if (cmd_f == KEY_STOP)  key_code = 3'b000;
    else                         key_hit  = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      addr         <= '0;
      cmd          <= '0;
      cmd_valid    <= 1'b0;
      repeat_pulse <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (state_reg == S_LEAD_HIGH && state_next == S_BIT_LOW) bit_cnt_reg <= '0;
      else if (ev_bit) bit_cnt_reg <= bit_cnt_reg + 5'd1;
      if (ev_bit) data_reg[bit_cnt_reg] <= bit_val;
      cmd_valid    <= frame_ok;
      repeat_pulse <= rep_ok;
      err          <= err_next;
      if (frame_ok) begin
        addr <= addr_f;
        cmd  <= cmd_f;
      end
    end
  end

  // A restart (mapped frame or accepted repeat) takes priority over expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_control   <= 3'b000;
      hold_active_reg <= 1'b0;
      hold_ms_reg     <= '0;
      hold_us_reg     <= '0;
    end else if ((frame_ok && key_hit) || rep_ok) begin
      if (frame_ok) state_control <= key_code;
      hold_active_reg <= 1'b1;
      hold_ms_reg     <= 16'(HOLD_MS);
      hold_us_reg     <= '0;
    end else if (hold_active_reg && tick) begin
      if (hold_us_reg == 10'd999) begin
        hold_us_reg <= '0;
        if (hold_ms_reg <= 16'd1) begin
          hold_active_reg <= 1'b0;
          state_control   <= 3'b000;
          hold_ms_reg     <= '0;
        end else begin
          hold_ms_reg <= hold_ms_reg - 16'd1;
        end
      end else begin
        hold_us_reg <= hold_us_reg + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_ctrl_rx.sv
// Drives NEC waveforms into two decoders (address checked / unchecked) and
// compares pulses, fields and the held motion code against a timed model.
`timescale 1ns/1ps
module tb_ir_nec_ctrl_rx;
  localparam int US     = 20;  // 1 us = 2 clk of 10 ns
  localparam int HOLD_A = 2;
  localparam int HOLD_B = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_in = 1'b1;
  logic [5:0]  sc_w;
  logic [15:0] addr_w, cmd_w;
  logic [1:0]  cv_w, rp_w, er_w;

  always #5 clk = ~clk;

  ir_nec_ctrl_rx #(.CLKS_PER_US(2), .HOLD_MS(HOLD_A), .CHECK_ADDR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .ir_in(ir_in), .state_control(sc_w[2:0]),
    .addr(addr_w[7:0]), .cmd(cmd_w[7:0]), .cmd_valid(cv_w[0]),
    .repeat_pulse(rp_w[0]), .err(er_w[0]));

  ir_nec_ctrl_rx #(.CLKS_PER_US(2), .HOLD_MS(HOLD_B), .CHECK_ADDR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ir_in(ir_in), .state_control(sc_w[5:3]),
    .addr(addr_w[15:8]), .cmd(cmd_w[15:8]), .cmd_valid(cv_w[1]),
    .repeat_pulse(rp_w[1]), .err(er_w[1]));

  int n_assert = 0;
  int n_fail   = 0;
  int cv_cnt[2], rp_cnt[2], er_cnt[2];
  int cv_s[2], rp_s[2], er_s[2];

  logic [2:0] code_m[2];
  logic [7:0] addr_m[2], cmd_m[2];
  bit         active_m[2];
  realtime    restart_t[2];
  real        hold_ns[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cv_w[i]) cv_cnt[i]++;
      if (rp_w[i]) rp_cnt[i]++;
      if (er_w[i]) er_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_sc(input int i);
    if (active_m[i] && (($realtime - restart_t[i]) < hold_ns[i])) return code_m[i];
    return 3'b000;
  endfunction

  function automatic bit map_key(input logic [7:0] c, output logic [2:0] code);
    code = 3'b000;
    case (c)
      8'h08: code = 3'b001;
      8'h5A: code = 3'b010;
      8'h18: code = 3'b011;
      8'h1C: code = 3'b101;
      8'h52: code = 3'b000;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      cv_s[i] = cv_cnt[i];
      rp_s[i] = rp_cnt[i];
      er_s[i] = er_cnt[i];
    end
  endtask

  task automatic ir_pulse(input int low_us, input int high_us);
    ir_in = 1'b0;
    #(low_us * US);
    ir_in = 1'b1;
    #(high_us * US);
  endtask

  task automatic send_frame(input logic [31:0] d);
    ir_pulse(9000, 4500);
    for (int k = 0; k < 32; k++) ir_pulse(560, d[k] ? 1690 : 560);
    ir_pulse(560, 0);
  endtask

  task automatic check_all(input string name, input int i, input int cv, input int rp,
                           input int er);
    chk($sformatf("%s.%0d.cmd_valid", name, i), 16'(cv_cnt[i] - cv_s[i]), 16'(cv));
    chk($sformatf("%s.%0d.repeat", name, i), 16'(rp_cnt[i] - rp_s[i]), 16'(rp));
    chk($sformatf("%s.%0d.err", name, i), 16'(er_cnt[i] - er_s[i]), 16'(er));
    chk($sformatf("%s.%0d.addr", name, i), 16'(addr_w[i*8 +: 8]), 16'(addr_m[i]));
    chk($sformatf("%s.%0d.cmd", name, i), 16'(cmd_w[i*8 +: 8]), 16'(cmd_m[i]));
    chk($sformatf("%s.%0d.state_control", name, i), 16'(sc_w[i*3 +: 3]), 16'(exp_sc(i)));
  endtask

  task automatic run_frame(input string name, input logic [31:0] d);
    bit valid[2];
    bit hit;
    logic [2:0] code;
    realtime t_end;
    snap();
    send_frame(d);
    t_end = $realtime;
    hit = map_key(d[23:16], code);
    for (int i = 0; i < 2; i++) begin
      valid[i] = ((d[23:16] ^ d[31:24]) == 8'hFF) && (i == 1 || ((d[7:0] ^ d[15:8]) == 8'hFF));
      if (valid[i]) begin
        addr_m[i] = d[7:0];
        cmd_m[i]  = d[23:16];
        if (hit) begin
          code_m[i]    = code;
          active_m[i]  = 1'b1;
          restart_t[i] = t_end;
        end
      end
    end
    #(100 * US);
    for (int i = 0; i < 2; i++) check_all(name, i, int'(valid[i]), 0, int'(!valid[i]));
    $display("txn %s data=%08h valid_a=%0d valid_b=%0d sc_a=%0d sc_b=%0d", name, d,
             valid[0], valid[1], sc_w[2:0], sc_w[5:3]);
  endtask

  task automatic run_repeat(input string name);
    bit acc[2];
    realtime t_end;
    snap();
    ir_pulse(9000, 2250);
    ir_pulse(560, 0);
    t_end = $realtime;
    for (int i = 0; i < 2; i++) begin
      acc[i] = active_m[i] && ((t_end - restart_t[i]) < hold_ns[i]);
      if (acc[i]) restart_t[i] = t_end;
    end
    #(100 * US);
    for (int i = 0; i < 2; i++) check_all(name, i, 0, int'(acc[i]), 0);
    $display("txn %s accepted_a=%0d accepted_b=%0d", name, acc[0], acc[1]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      code_m[i]   = 3'b000;
      addr_m[i]   = 8'h00;
      cmd_m[i]    = 8'h00;
      active_m[i] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  keys[6];
    logic [7:0]  a, c, an, cn;
    int          corrupt;
    hold_ns[0] = real'(HOLD_A) * 1000.0 * US;
    hold_ns[1] = real'(HOLD_B) * 1000.0 * US;
    model_reset();
    snap();

    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #(200 * US);
    for (int i = 0; i < 2; i++) check_all("reset", i, 0, 0, 0);
    $display("txn reset sc_a=%0d sc_b=%0d", sc_w[2:0], sc_w[5:3]);

    run_frame("left", 32'hF7_08_FF_00);
    #(900 * US);
    run_repeat("repeat");
    #(12900 * US);
    for (int i = 0; i < 2; i++)
      chk($sformatf("hold_mid.%0d.state_control", i), 16'(sc_w[i*3 +: 3]), 16'(exp_sc(i)));
    $display("txn hold_mid sc_b=%0d", sc_w[5:3]);
    #(3000 * US);
    for (int i = 0; i < 2; i++)
      chk($sformatf("hold_end.%0d.state_control", i), 16'(sc_w[i*3 +: 3]), 16'(exp_sc(i)));
    $display("txn hold_end sc_b=%0d", sc_w[5:3]);

    run_frame("bad_cmd_n", 32'hE2_1C_FF_00);
    run_frame("bad_addr_n", 32'hE3_1C_00_00);

    snap();
    ir_pulse(7000, 100);
    for (int i = 0; i < 2; i++) check_all("short_leader", i, 0, 0, 1);
    $display("txn short_leader err_a=%0d err_b=%0d", er_cnt[0] - er_s[0], er_cnt[1] - er_s[1]);
    #(1000 * US);
    run_frame("right", 32'hA5_5A_FF_00);

    d = 32'hE7_18_FF_00;
    snap();
    ir_pulse(9000, 4500);
    for (int k = 0; k < 16; k++) ir_pulse(560, d[k] ? 1690 : 560);
    rst = 1'b1;
    model_reset();
    #(50 * US);
    for (int i = 0; i < 2; i++) check_all("mid_reset", i, 0, 0, 0);
    $display("txn mid_reset sc_a=%0d addr_b=%0h", sc_w[2:0], addr_w[15:8]);
    rst = 1'b0;
    #(1000 * US);
    run_frame("fwd_after_reset", d);

    keys = '{8'h08, 8'h5A, 8'h18, 8'h1C, 8'h52, 8'h00};
    for (int n = 0; n < 3; n++) begin
      keys[5] = 8'($urandom);
      a  = 8'($urandom);
      c  = keys[$urandom_range(0, 5)];
      an = ~a;
      cn = ~c;
      corrupt = int'($urandom_range(0, 2));
      if (corrupt == 1) cn = cn ^ (8'h01 << $urandom_range(0, 7));
      if (corrupt == 2) an = an ^ (8'h01 << $urandom_range(0, 7));
      run_frame($sformatf("rand%0d", n), {cn, c, an, a});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
